// File: rtl/opamp_pkg.sv
// Shared types and constants for the op-amp gain-range scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package opamp_pkg;

  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_TRACK   = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_SETTLE  = 2'd2
  } state_t;

  // IEEE-754 single-precision gains, one per range (low magnitude -> high gain).
  localparam logic [31:0] GAIN_270 = 32'h4387_0000;
  localparam logic [31:0] GAIN_100 = 32'h42C8_0000;
  localparam logic [31:0] GAIN_50  = 32'h4248_0000;
  localparam logic [31:0] GAIN_10  = 32'h4120_0000;

  function automatic logic [31:0] gain_of(input idx_t idx);
    logic [31:0] g;
    case (idx)
      2'd0:    g = GAIN_270;
      2'd1:    g = GAIN_100;
      2'd2:    g = GAIN_50;
      default: g = GAIN_10;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/gain_range_decode.sv
// Maps an unsigned magnitude onto one of four gain ranges by threshold compare.
// Latency: combinational.
// Backpressure: none; pure function of the input.
module gain_range_decode
  import opamp_pkg::*;
#(
  parameter int W  = 16,
  parameter int T1 = 100,
  parameter int T2 = 500,
  parameter int T3 = 2400
) (
  input  logic [W-1:0] v_i,
  output idx_t         idx_o
);

  // Range 0 and 1 upper bounds are inclusive; range 3 lower bound is inclusive.
  always_comb begin
    idx_o = 2'd0;
    if (v_i >= W'(T3))      idx_o = 2'd3;
    else if (v_i > W'(T2))  idx_o = 2'd2;
    else if (v_i > W'(T1))  idx_o = 2'd1;
  end

endmodule

// File: rtl/opamp_gain_scheduler.sv
// Gain-range controller: hysteresis + dwell qualification, then a hold window after each switch.
// Latency: qualified switch lands one edge after the qualifying sample; force switch on the sampling edge.
// Backpressure: none; samples arriving during the hold window are dropped.
module opamp_gain_scheduler
  import opamp_pkg::*;
#(
  parameter int C_WIDTH    = 16,
  parameter int T1         = 100,
  parameter int T2         = 500,
  parameter int T3         = 2400,
  parameter int HYST       = 8,
  parameter int DWELL      = 4,
  parameter int SETTLE_CYC = 16
) (
  input  logic               clk_100k,
  input  logic               reset_n,
  input  logic [C_WIDTH-1:0] non_inv,
  input  logic               in_valid,
  input  logic               force_en,
  input  logic [1:0]         force_idx,
  output logic [31:0]        gain,
  output logic [1:0]         gain_idx,
  output logic               gain_change,
  output logic               hold,
  output logic               busy
);

  localparam int DW_W = $clog2(DWELL + 1);
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t            state_q, state_d;
  idx_t              gain_idx_q, gain_idx_d;
  logic [31:0]       gain_q, gain_d;
  logic              gain_change_q, gain_change_d;
  logic              hold_q, hold_d;
  idx_t              cand_q, cand_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [SC_W-1:0]   settle_q, settle_d;
  // Set on the qualifying sample edge; the switch itself lands on the next edge.
  logic              pend_q, pend_d;

  logic [C_WIDTH:0]   dn_sum;
  logic [C_WIDTH-1:0] dn_sat;
  idx_t               raw_up;
  idx_t               raw_dn;
  idx_t               tgt;
  logic [DW_W-1:0]    dwell_inc;
  logic               do_sw;
  idx_t               sw_idx;

  // Downward decisions look at the sample pushed up by the hysteresis margin, saturated.
  always_comb begin
    dn_sum = {1'b0, non_inv} + (C_WIDTH + 1)'(HYST);
    dn_sat = dn_sum[C_WIDTH] ? '1 : dn_sum[C_WIDTH-1:0];
  end

  gain_range_decode #(.W(C_WIDTH), .T1(T1), .T2(T2), .T3(T3)) u_dec_up (
    .v_i   (non_inv),
    .idx_o (raw_up)
  );

  gain_range_decode #(.W(C_WIDTH), .T1(T1), .T2(T2), .T3(T3)) u_dec_dn (
    .v_i   (dn_sat),
    .idx_o (raw_dn)
  );

  // Target range: climb at the plain threshold, descend only past the margin.
  always_comb begin
    tgt = gain_idx_q;
    if (raw_up > gain_idx_q)      tgt = raw_up;
    else if (raw_dn < gain_idx_q) tgt = raw_dn;
  end

  assign dwell_inc = dwell_q + 1'b1;

  // Next-state logic: dwell qualification, settle countdown, force override.
  always_comb begin
    state_d       = state_q;
    gain_idx_d    = gain_idx_q;
    gain_d        = gain_q;
    gain_change_d = 1'b0;
    hold_d        = hold_q;
    cand_d        = cand_q;
    dwell_d       = dwell_q;
    settle_d      = settle_q;
    pend_d        = pend_q;
    do_sw         = 1'b0;
    sw_idx        = cand_q;

    case (state_q)
      ST_TRACK: begin
        if (!force_en && in_valid && (tgt != gain_idx_q)) begin
          cand_d  = tgt;
          dwell_d = DW_W'(1);
          pend_d  = (DWELL == 1);
          state_d = ST_QUALIFY;
        end
      end
      ST_QUALIFY: begin
        if (force_en) begin
          if (force_idx == gain_idx_q) begin
            state_d = ST_TRACK;
            dwell_d = '0;
            pend_d  = 1'b0;
          end
        end else if (pend_q) begin
          do_sw = 1'b1;
        end else if (in_valid) begin
          if (tgt == cand_q) begin
            dwell_d = dwell_inc;
            pend_d  = (dwell_inc == DW_W'(DWELL));
          end else if (tgt == gain_idx_q) begin
            state_d = ST_TRACK;
            dwell_d = '0;
          end else begin
            cand_d  = tgt;
            dwell_d = DW_W'(1);
            pend_d  = (DWELL == 1);
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          hold_d  = 1'b0;
          state_d = ST_TRACK;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: state_d = ST_TRACK;
    endcase

    if (force_en && (force_idx != gain_idx_q)) begin
      do_sw  = 1'b1;
      sw_idx = force_idx;
    end

    if (do_sw) begin
      gain_idx_d    = sw_idx;
      gain_d        = gain_of(sw_idx);
      gain_change_d = 1'b1;
      hold_d        = 1'b1;
      settle_d      = SC_W'(SETTLE_CYC - 1);
      state_d       = ST_SETTLE;
      dwell_d       = '0;
      pend_d        = 1'b0;
    end
  end

  // State and output registers; reset drops hold and restores range 0 at once.
  always_ff @(posedge clk_100k or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_TRACK;
      gain_idx_q    <= 2'd0;
      gain_q        <= GAIN_270;
      gain_change_q <= 1'b0;
      hold_q        <= 1'b0;
      cand_q        <= 2'd0;
      dwell_q       <= '0;
      settle_q      <= '0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gain_idx_q    <= gain_idx_d;
      gain_q        <= gain_d;
      gain_change_q <= gain_change_d;
      hold_q        <= hold_d;
      cand_q        <= cand_d;
      dwell_q       <= dwell_d;
      settle_q      <= settle_d;
      pend_q        <= pend_d;
    end
  end

  assign gain        = gain_q;
  assign gain_idx    = gain_idx_q;
  assign gain_change = gain_change_q;
  assign hold        = hold_q;
  assign busy        = (state_q != ST_TRACK);

endmodule

// File: doc/opamp_gain_scheduler.md
Name: opamp_gain_scheduler

Overview:
- Sequential gain-range controller for the floating-point op-amp loop.
- Replaces the combinational threshold mux that feeds the IEEE-754 gain multiplier.
- Selects one of four gain ranges from the input magnitude, using hysteresis and dwell qualification to prevent range chatter.
- After each range switch, asserts a hold window so the downstream IIR filter and sample registers can freeze while the loop settles.

Parameters:
- C_WIDTH, 16, width of the unsigned input magnitude non_inv.
- T1, 100, upper bound of range 0 (inclusive).
- T2, 500, upper bound of range 1 (inclusive).
- T3, 2400, lower bound of range 3 (inclusive).
- HYST, 8, downward hysteresis margin in input LSBs.
- DWELL, 4, number of consecutive qualifying samples required before a switch.
- SETTLE_CYC, 16, length of the hold window in clk_100k cycles.

Ports:
- clk_100k, input, 1, loop clock.
- reset_n, input, 1, asynchronous active-low reset.
- non_inv, input, C_WIDTH, unsigned input magnitude.
- in_valid, input, 1, one-cycle strobe marking a new non_inv sample.
- force_en, input, 1, configuration override strobe.
- force_idx, input, 2, range index applied when force_en=1.
- gain, output, 32, IEEE-754 single-precision gain for the current range (registered).
- gain_idx, output, 2, current range index (registered).
- gain_change, output, 1, one-cycle pulse on the cycle gain updates.
- hold, output, 1, high during the settle window.
- busy, output, 1, high while in QUALIFY or SETTLE.

Behaviour:
- Reset is asynchronous and active-low. Reset is decided as reset_n, asynchronous, active-low; clock is clk_100k.
- Values on reset: gain_idx=0, gain=0x43870000, gain_change=0, hold=0, busy=0, dwell counter=0, settle counter=0, state=TRACK.
- Range map:
  - idx0 (non_inv<=T1): gain 270 = 0x43870000.
  - idx1 (T1<non_inv<=T2): gain 100 = 0x42C80000.
  - idx2 (T2<non_inv<T3): gain 50 = 0x42480000.
  - idx3 (non_inv>=T3): gain 10 = 0x41200000.
- raw(v) denotes the range index of v.
- Target computation, evaluated only when in_valid=1:
  - If raw(non_inv) > gain_idx, tgt = raw(non_inv).
  - Otherwise dn = raw(min(non_inv+HYST, 2^C_WIDTH-1)), computed at C_WIDTH+1 bits and saturated.
  - If dn < gain_idx, tgt = dn; otherwise tgt = gain_idx.
  - Upward moves are immediate-threshold; downward moves require a margin of HYST.
  - A switch may jump more than one range.
- FSM states:
  - TRACK: on in_valid with tgt != gain_idx, latch cand=tgt, set dwell=1, go to QUALIFY. If DWELL==1, switch directly.
  - QUALIFY, on in_valid:
    - tgt==cand: dwell+1. When dwell reaches DWELL, switch.
    - tgt==gain_idx: clear dwell, return to TRACK.
    - any other tgt: cand=tgt, dwell=1.
    - Cycles without in_valid leave the state unchanged.
  - Switch: on the next edge, gain_idx<=cand, gain<=map(cand), gain_change=1 for one cycle, hold=1, settle counter=SETTLE_CYC-1, go to SETTLE. Latency is one clk_100k edge after the qualifying sample edge.
  - SETTLE: hold=1. The counter decrements every cycle. in_valid is ignored and not counted. At 0, hold<=0 and the FSM goes to TRACK on the following edge. Hold stays high for exactly SETTLE_CYC cycles.
- force_en has priority over everything:
  - If force_idx != gain_idx: apply a switch to force_idx (gain_change, SETTLE restart), clear dwell.
  - If force_idx == gain_idx: no gain_change; the state machine is unchanged unless in QUALIFY, which returns to TRACK.
  - force_en during SETTLE with a different index restarts the settle window.
- Reset mid-QUALIFY or mid-SETTLE: all state returns to reset values immediately; hold drops asynchronously.
- busy = (state != TRACK).

Decomposition:
- Shared package opamp_pkg:
  - IEEE gain constants GAIN_270, GAIN_100, GAIN_50, GAIN_10.
  - Range index width and state encoding (TRACK, QUALIFY, SETTLE).
- One sub-module, gain_range_decode: a combinational function raw(v) with the thresholds as parameters, instantiated twice (non_inv and non_inv+HYST).
- FSM, counters and output registers live in the top module.

Test Plan:
- Reset: release reset with non_inv=50 and no in_valid -> gain_idx=0, gain=0x43870000, hold=0, gain_change=0.
- Step up: 4 in_valid samples of 600 from idx0 -> after the 4th sample edge, one edge later gain_idx=2, gain=0x42480000, gain_change for 1 cycle, hold high for 16 cycles, then TRACK.
- Chatter rejection: at idx1, samples alternate 505/495 for 20 samples -> no switch and gain_change never asserts (dwell resets on each 495).
- Hysteresis down: at idx2, 4 samples of 495 -> stays idx2 (495+8 lands in idx2); 4 samples of 490 -> switches to idx1, gain=0x42C80000.
- Interrupted dwell plus SETTLE ignore: at idx0, samples 3000,3000,3000,1000,3000×4 -> single switch to idx3 (gain 0x41200000) only after the last 4. Samples of 50 during hold are ignored, with no QUALIFY entry until hold drops.
- Force and reset mid-op:
  - force_en with force_idx=3 during QUALIFY -> gain 0x41200000 next edge, hold restarts.
  - Assert reset_n=0 mid-SETTLE -> hold=0 and gain=0x43870000 immediately.
